// File: rtl/video_modulator_pkg.sv
// Shared types and constants for the composite video subcarrier path.
package video_modulator_pkg;

    localparam int          PHASE_W      = 9;
    localparam logic [8:0]  QUARTER_TURN = 9'd128;
    localparam int          LUT_LATENCY  = 1;

    // One accepted sample walks IDLE -> ADDR_COS -> ADDR_SIN -> CAP_SIN -> IDLE.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ADDR_COS = 2'd1,
        ST_ADDR_SIN = 2'd2,
        ST_CAP_SIN  = 2'd3
    } state_e;

endpackage

// File: rtl/video_burst_window.sv
// Per-line window generator: counts clocks from line_start and flags
// the span [START, START+LEN). The counter parks at all-ones so the
// window stays closed until the first line_start after reset.
module video_burst_window #(
    parameter int START = 80,
    parameter int LEN   = 36,
    parameter int CNT_W = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic line_start_i,
    output logic active_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // One extra bit so START+LEN never wraps in the compare.
    localparam logic [CNT_W:0]   WIN_LO  = (CNT_W+1)'(START);
    localparam logic [CNT_W:0]   WIN_HI  = (CNT_W+1)'(START + LEN);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: line_start restarts, otherwise count up and saturate.
    always_comb begin
        count_d = count_q;
        if (line_start_i) begin
            count_d = '0;
        end else if (count_q != CNT_MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register, parked at all-ones out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= CNT_MAX;
        end else begin
            count_q <= count_d;
        end
    end

    assign active_o = ({1'b0, count_q} >= WIN_LO) && ({1'b0, count_q} < WIN_HI);

endmodule

// File: rtl/video_modulator_subcarrier_ctrl.sv
// Chroma subcarrier sequencer: runs the phase accumulator, applies hue
// or burst phase, and time-shares one external 1-cycle cosine LUT to
// produce a cos/sin pair per accepted sample.
module video_modulator_subcarrier_ctrl
    import video_modulator_pkg::*;
#(
    parameter int          ACC_W       = 24,
    parameter int unsigned PHASE_INC   = 32'd2402184,
    parameter int          BURST_START = 80,
    parameter int          BURST_LEN   = 36,
    parameter logic [8:0]  BURST_PHASE = 9'd256,
    parameter int          CNT_W       = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en,
    output logic                ready,
    input  logic                line_start,
    input  logic [PHASE_W-1:0]  phase_offset,
    output logic [PHASE_W-1:0]  lut_phase,
    input  logic [7:0]          lut_value,
    output logic [7:0]          cos_out,
    output logic [7:0]          sin_out,
    output logic                valid,
    output logic                burst_active,
    output logic                overrun
);

    localparam logic [ACC_W-1:0] INC = ACC_W'(PHASE_INC);

    state_e               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [7:0]           cos_cap_q, cos_cap_d;
    logic [7:0]           cos_q, cos_d;
    logic [7:0]           sin_q, sin_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic [PHASE_W-1:0]   offset;

    video_burst_window #(
        .START (BURST_START),
        .LEN   (BURST_LEN),
        .CNT_W (CNT_W)
    ) u_burst (
        .clk          (clk),
        .reset        (reset),
        .line_start_i (line_start),
        .active_o     (burst_active)
    );

    // Burst state is sampled at acceptance only; an in-flight pair keeps
    // the phase it started with since lut_phase already holds it.
    assign offset = burst_active ? BURST_PHASE : phase_offset;

    // Next-state and datapath: LUT address is issued one cycle ahead of
    // each capture to cover the LUT's registered read.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        phase_d   = phase_q;
        cos_cap_d = cos_cap_q;
        cos_d     = cos_q;
        sin_d     = sin_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q | (sample_en && (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (sample_en) begin
                    phase_d = acc_q[ACC_W-1 -: PHASE_W] + offset;
                    acc_d   = acc_q + INC;
                    state_d = ST_ADDR_COS;
                end
            end
            ST_ADDR_COS: begin
                // sin(p) = cos(p - 90 deg)
                phase_d = phase_q - QUARTER_TURN;
                state_d = ST_ADDR_SIN;
            end
            ST_ADDR_SIN: begin
                cos_cap_d = lut_value;
                state_d   = ST_CAP_SIN;
            end
            ST_CAP_SIN: begin
                cos_d   = cos_cap_q;
                sin_d   = lut_value;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            phase_q   <= '0;
            cos_cap_q <= '0;
            cos_q     <= '0;
            sin_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            phase_q   <= phase_d;
            cos_cap_q <= cos_cap_d;
            cos_q     <= cos_d;
            sin_q     <= sin_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign lut_phase = phase_q;
    assign cos_out   = cos_q;
    assign sin_out   = sin_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_video_modulator_subcarrier_ctrl.sv
// Bench: two DUTs share stimulus. Instance 0 uses small test parameters
// (quarter-turn step, short burst window) for hand-computed checks;
// instance 1 uses the default parameters. Both run against a
// transaction-level model on every cycle.
module tb_video_modulator_subcarrier_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       sample_en = 1'b0;
    logic       line_start = 1'b0;
    logic [8:0] phase_offset = '0;

    logic [1:0] ready, valid, burst, ovr;
    logic [8:0] lut_phase [2];
    logic [7:0] lut_value [2];
    logic [7:0] cos_o [2];
    logic [7:0] sin_o [2];

    int checks = 0;
    int errors = 0;

    video_modulator_subcarrier_ctrl #(
        .PHASE_INC   (32'd4194304),
        .BURST_START (4),
        .BURST_LEN   (3)
    ) dut0 (
        .clk(clk), .reset(reset), .sample_en(sample_en), .ready(ready[0]),
        .line_start(line_start), .phase_offset(phase_offset),
        .lut_phase(lut_phase[0]), .lut_value(lut_value[0]),
        .cos_out(cos_o[0]), .sin_out(sin_o[0]), .valid(valid[0]),
        .burst_active(burst[0]), .overrun(ovr[0])
    );

    video_modulator_subcarrier_ctrl dut1 (
        .clk(clk), .reset(reset), .sample_en(sample_en), .ready(ready[1]),
        .line_start(line_start), .phase_offset(phase_offset),
        .lut_phase(lut_phase[1]), .lut_value(lut_value[1]),
        .cos_out(cos_o[1]), .sin_out(sin_o[1]), .valid(valid[1]),
        .burst_active(burst[1]), .overrun(ovr[1])
    );

    // Cosine table: round(100*cos(2*pi*p/512)) as 8-bit two's complement.
    function automatic logic [7:0] lut_fn(input int p);
        real r;
        int  v;
        r = 100.0 * $cos(2.0 * 3.14159265358979 * p / 512.0);
        v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
        return 8'(v);
    endfunction

    // External LUTs, one registered read each.
    always @(posedge clk) begin
        lut_value[0] <= lut_fn(int'(lut_phase[0]));
        lut_value[1] <= lut_fn(int'(lut_phase[1]));
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int M_INC [2] = '{4194304, 2402184};
    int M_BS  [2] = '{4, 80};
    int M_BL  [2] = '{3, 36};

    int m_acc [2], m_cnt [2], m_left [2], m_p [2];
    int m_phase [2], m_cos [2], m_sin [2];
    bit m_valid [2], m_ovr [2];
    bit live = 1'b0;

    function automatic bit m_win(input int i);
        return (m_cnt[i] >= M_BS[i]) && (m_cnt[i] < M_BS[i] + M_BL[i]);
    endfunction

    // m_left = cycles still owed by the pair in flight (0 = free).
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_acc[i] = 0; m_cnt[i] = 2047; m_left[i] = 0; m_p[i] = 0;
                m_phase[i] = 0; m_cos[i] = 0; m_sin[i] = 0;
                m_valid[i] = 1'b0; m_ovr[i] = 1'b0;
            end else begin
                m_valid[i] = 1'b0;
                if (m_left[i] == 0) begin
                    if (sample_en) begin
                        m_p[i] = ((m_acc[i] >> 15) + (m_win(i) ? 256 : int'(phase_offset))) % 512;
                        m_phase[i] = m_p[i];
                        m_acc[i] = (m_acc[i] + M_INC[i]) % (1 << 24);
                        m_left[i] = 3;
                    end
                end else begin
                    if (sample_en) m_ovr[i] = 1'b1;
                    if (m_left[i] == 3) m_phase[i] = (m_p[i] + 384) % 512;
                    if (m_left[i] == 1) begin
                        m_cos[i] = int'(lut_fn(m_p[i]));
                        m_sin[i] = int'(lut_fn((m_p[i] + 384) % 512));
                        m_valid[i] = 1'b1;
                    end
                    m_left[i]--;
                end
                if (line_start) m_cnt[i] = 0;
                else if (m_cnt[i] != 2047) m_cnt[i]++;
            end
        end
        if (reset) live = 1'b1;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (live) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("m%0d_ready", i), int'(ready[i]), (m_left[i] == 0) ? 1 : 0);
                chk($sformatf("m%0d_valid", i), int'(valid[i]), int'(m_valid[i]));
                chk($sformatf("m%0d_cos", i), int'(cos_o[i]), m_cos[i]);
                chk($sformatf("m%0d_sin", i), int'(sin_o[i]), m_sin[i]);
                chk($sformatf("m%0d_phase", i), int'(lut_phase[i]), m_phase[i]);
                chk($sformatf("m%0d_burst", i), int'(burst[i]), int'(m_win(i)));
                chk($sformatf("m%0d_ovr", i), int'(ovr[i]), int'(m_ovr[i]));
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic nclk(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nclk(1);
        reset = 1'b0;
    endtask

    // Issue one sample at the current negedge and check the result 4 cycles on.
    task automatic sample_chk(input string nm, input logic [8:0] po, input int ec, input int es);
        sample_en = 1'b1;
        phase_offset = po;
        nclk(1);
        sample_en = 1'b0;
        for (int k = 1; k < 4; k++) begin
            chk({nm, "_novalid"}, int'(valid[0]), 0);
            nclk(1);
        end
        chk({nm, "_valid"}, int'(valid[0]), 1);
        chk({nm, "_cos"}, int'(cos_o[0]), ec);
        chk({nm, "_sin"}, int'(sin_o[0]), es);
    endtask

    int exp_c [4] = '{100, 0, 156, 0};
    int exp_s [4] = '{0, 100, 0, 156};
    int b4 [9]  = '{0, 0, 0, 0, 1, 1, 1, 0, 0};
    int b5 [14] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0};

    initial begin
        // Reset state
        nclk(3);
        chk("rst_ready", int'(ready[0]), 1);
        chk("rst_valid", int'(valid[0]), 0);
        chk("rst_cos", int'(cos_o[0]), 0);
        chk("rst_sin", int'(sin_o[0]), 0);
        chk("rst_ovr", int'(ovr[0]), 0);
        chk("rst_phase", int'(lut_phase[0]), 0);
        chk("rst_burst", int'(burst[0]), 0);
        reset = 1'b0;
        nclk(1);

        // Quarter-turn accumulator, back-to-back at full rate
        for (int k = 0; k < 4; k++)
            sample_chk($sformatf("t1_%0d", k), 9'd0, exp_c[k], exp_s[k]);

        // Hue offset
        do_reset();
        sample_chk("t2_128", 9'd128, 0, 100);
        do_reset();
        sample_chk("t2_511", 9'd511, 100, 255);

        // Overrun: second request in the busy cycle is dropped
        do_reset();
        sample_en = 1'b1;
        nclk(1);
        nclk(1);
        sample_en = 1'b0;
        chk("t3_ovr_set", int'(ovr[0]), 1);
        nclk(2);
        chk("t3_first_cos", int'(cos_o[0]), 100);
        sample_chk("t3_next", 9'd0, 0, 100);
        chk("t3_ovr_sticky", int'(ovr[0]), 1);
        do_reset();
        chk("t3_ovr_clr", int'(ovr[0]), 0);

        // Burst window and burst phase
        do_reset();
        line_start = 1'b1;
        nclk(1);
        line_start = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            chk($sformatf("t4_burst_%0d", j), int'(burst[0]), b4[j-1]);
            sample_en = (j == 6);
            phase_offset = 9'd0;
            nclk(1);
        end
        sample_en = 1'b0;
        chk("t4_cos", int'(cos_o[0]), 156);
        chk("t4_sin", int'(sin_o[0]), 0);

        // line_start inside an open window restarts it
        line_start = 1'b1;
        nclk(1);
        line_start = 1'b0;
        for (int j = 1; j <= 14; j++) begin
            chk($sformatf("t5_burst_%0d", j), int'(burst[0]), b5[j-1]);
            line_start = (j == 6);
            nclk(1);
        end
        line_start = 1'b0;
        nclk(2100);
        chk("t5_sat_closed", int'(burst[0]), 0);
        line_start = 1'b1;
        nclk(1);
        line_start = 1'b0;
        nclk(4);
        chk("t5_sat_restart", int'(burst[0]), 1);

        // Reset during ADDR_SIN drops the pair
        do_reset();
        sample_en = 1'b1;
        nclk(1);
        sample_en = 1'b0;
        nclk(1);
        reset = 1'b1;
        nclk(1);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t6_novalid", int'(valid[0]), 0);
            chk("t6_ready", int'(ready[0]), 1);
            chk("t6_cos", int'(cos_o[0]), 0);
            chk("t6_sin", int'(sin_o[0]), 0);
            nclk(1);
        end
        sample_chk("t6_acc0", 9'd0, 100, 0);

        // Random traffic, both instances checked by the model
        for (int k = 0; k < 6000; k++) begin
            reset        = ($urandom_range(0, 499) == 0);
            sample_en    = ($urandom_range(0, 99) < 45);
            line_start   = ($urandom_range(0, 179) == 0);
            phase_offset = 9'($urandom_range(0, 511));
            nclk(1);
        end
        reset = 1'b0;
        sample_en = 1'b0;
        line_start = 1'b0;
        nclk(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
